// File: rtl/cte_stream_host.sv
`timescale 1ns/1ps
// cte_fifo: small prefetch FIFO with registered storage; the head is read straight from storage.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
module cte_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push_vld && !pop)      count <= count + 1'b1;
            else if (!push_vld && pop) count <= count - 1'b1;
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// cte_stream_host: per job fetches source words, streams them into the CTE and writes CTE results out.
// Latency: src word can reach cte_in_en 2 cycles after its src_rd; results are written 1 cycle after out_valid.
// Backpressure: cte_busy stalls cte_in_en; the 2-entry prefetch FIFO throttles src_rd; results are never stalled.
module cte_stream_host #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] num_pairs,
    output logic              host_busy,
    output logic              done,
    output logic              err_timeout,
    output logic              src_rd,
    output logic [ADDR_W+1:0] src_addr,
    input  logic [23:0]       src_data,
    output logic              dst_wr,
    output logic [ADDR_W+1:0] dst_addr,
    output logic [23:0]       dst_data,
    output logic              cte_op_mode,
    output logic              cte_in_en,
    output logic [7:0]        cte_yuv_in,
    output logic [23:0]       cte_rgb_in,
    input  logic              cte_busy,
    input  logic              cte_out_valid,
    input  logic [23:0]       cte_rgb_out,
    input  logic [7:0]        cte_yuv_out
);
    localparam int CW = ADDR_W + 2;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic          op_mode;
    logic [CW-1:0] in_total;
    logic [CW-1:0] out_total;
    logic [CW-1:0] fetch_cnt;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [IW-1:0] idle_cnt;
    logic          rd_pend;
    logic [1:0]    fifo_cnt;
    logic [23:0]   fifo_head;
    logic          job_go;
    logic          cap;
    logic          timed_out;
    logic          active;
    logic          abort;
    logic [CW-1:0] pairs_x2;
    logic [CW-1:0] pairs_x4;

    // Counters are two bits wider than num_pairs so 4*num_pairs never wraps.
    assign pairs_x2  = {1'b0, num_pairs, 1'b0};
    assign pairs_x4  = {num_pairs, 2'b00};
    assign job_go    = (state == S_IDLE) && start;
    assign active    = (state == S_RUN) || (state == S_DRAIN);
    assign timed_out = (idle_cnt == IW'(TIMEOUT));
    // A DRAIN that completes on the same cycle the timer expires is treated as a clean finish.
    assign abort     = active && timed_out && !((state == S_DRAIN) && (out_cnt == out_total));

    // Only registered state and cte_busy feed the CTE strobe.
    assign cte_in_en = (state == S_RUN) && (fifo_cnt != 2'd0) && !cte_busy;
    // Reads in flight count against FIFO space so a returning word always has a slot.
    assign src_rd    = (state == S_RUN) && (fetch_cnt < in_total) &&
                       ((fifo_cnt + {1'b0, rd_pend}) < 2'd2);
    assign src_addr  = fetch_cnt;
    assign cap       = active && cte_out_valid && (out_cnt < out_total);

    assign cte_op_mode = op_mode;
    assign cte_yuv_in  = fifo_head[7:0];
    assign cte_rgb_in  = fifo_head;

    cte_fifo #(.W(24), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (job_go),
        .push_vld (rd_pend),
        .push_dat (src_data),
        .pop      (cte_in_en),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

    // Job sequencing: run until all inputs issued, drain until all results captured, or abort on timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = (num_pairs == '0) ? S_DONE : S_RUN;
            S_RUN:   if (timed_out) next_state = S_DONE;
                     else if (in_cnt == in_total) next_state = S_DRAIN;
            S_DRAIN: if ((out_cnt == out_total) || timed_out) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Job parameters, progress counters, progress watchdog and the sticky abort flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_mode     <= 1'b0;
            in_total    <= '0;
            out_total   <= '0;
            fetch_cnt   <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            rd_pend <= src_rd;
            if (job_go) begin
                op_mode     <= mode;
                in_total    <= mode ? pairs_x2 : pairs_x4;
                out_total   <= mode ? pairs_x4 : pairs_x2;
                fetch_cnt   <= '0;
                in_cnt      <= '0;
                out_cnt     <= '0;
                idle_cnt    <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (src_rd)    fetch_cnt <= fetch_cnt + 1'b1;
                if (cte_in_en) in_cnt    <= in_cnt + 1'b1;
                if (cap)       out_cnt   <= out_cnt + 1'b1;
                if (cte_in_en || cap)          idle_cnt <= '0;
                else if (active && !timed_out) idle_cnt <= idle_cnt + 1'b1;
                if (abort) err_timeout <= 1'b1;
            end
        end
    end

    // Registered host status and result-memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_busy <= 1'b0;
            done      <= 1'b0;
            dst_wr    <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= '0;
        end else begin
            host_busy <= (next_state != S_IDLE) || (state == S_DONE);
            done      <= (state == S_DONE);
            dst_wr    <= cap;
            if (cap) begin
                dst_addr <= out_cnt;
                dst_data <= op_mode ? {16'b0, cte_yuv_out} : cte_rgb_out;
            end
        end
    end
endmodule

// File: tb/tb_cte_stream_host.sv
`timescale 1ns/1ps
module tb_cte_stream_host;
    localparam int ADDR_W = 16;
    localparam int TO     = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [ADDR_W-1:0] num_pairs = '0;
    logic              host_busy, done, err_timeout, src_rd, dst_wr, cte_op_mode, cte_in_en;
    logic [ADDR_W+1:0] src_addr, dst_addr;
    logic [23:0]       dst_data, cte_rgb_in;
    logic [7:0]        cte_yuv_in;
    logic [23:0]       src_data = '0;
    logic              cte_busy = 1'b0;
    logic              cte_out_valid = 1'b0;
    logic [23:0]       cte_rgb_out = '0;
    logic [7:0]        cte_yuv_out = '0;

    cte_stream_host #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .num_pairs(num_pairs),
        .host_busy(host_busy), .done(done), .err_timeout(err_timeout),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .dst_wr(dst_wr), .dst_addr(dst_addr), .dst_data(dst_data),
        .cte_op_mode(cte_op_mode), .cte_in_en(cte_in_en), .cte_yuv_in(cte_yuv_in),
        .cte_rgb_in(cte_rgb_in), .cte_busy(cte_busy), .cte_out_valid(cte_out_valid),
        .cte_rgb_out(cte_rgb_out), .cte_yuv_out(cte_yuv_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory and CTE stub state
    logic [23:0] src_mem [16];
    logic [23:0] res_tab [16];
    logic [23:0] in_log  [32];
    logic [23:0] dst_d   [32];
    logic [17:0] dst_a   [32];
    logic [17:0] rd_addr_tb, first_rd_addr;
    logic        rd_pend_tb = 1'b0;
    logic        stall_on, out_en, mode_tb;
    int in_seen, emitted, n_res, n_wr, n_rd, n_done, busy_viol, op_bad, stall_left;
    int cyc = 0;
    int last_in_cyc, done_cyc, start_cyc;

    task automatic clear_stub();
        in_seen = 0; emitted = 0; n_wr = 0; n_rd = 0; n_done = 0;
        busy_viol = 0; op_bad = 0; stall_left = 0; stall_on = 1'b0; out_en = 1'b1;
        last_in_cyc = 0; done_cyc = 0; first_rd_addr = '1;
    endtask

    // Stub: drive at +1 after the edge, observe at +2.
    initial begin : stub
        int allowed;
        forever begin
            @(posedge clk);
            #1;
            src_data = rd_pend_tb ? src_mem[rd_addr_tb[3:0]] : 24'h0;
            cte_busy = (stall_left != 0);
            if (stall_left != 0) stall_left--;
            allowed = mode_tb ? in_seen * 2 : in_seen / 2;
            if (out_en && emitted < allowed && emitted < n_res) begin
                cte_out_valid = 1'b1;
                cte_yuv_out   = res_tab[emitted][7:0];
                cte_rgb_out   = mode_tb ? 24'hABCDEF : res_tab[emitted];
                emitted++;
            end else begin
                cte_out_valid = 1'b0;
            end
            #1;
            cyc++;
            rd_pend_tb = src_rd;
            rd_addr_tb = src_addr;
            if (src_rd) begin
                if (n_rd == 0) first_rd_addr = src_addr;
                n_rd++;
            end
            if (cte_in_en) begin
                if (cte_busy) busy_viol++;
                if (in_seen < 32) in_log[in_seen] = mode_tb ? cte_rgb_in : {16'h0, cte_yuv_in};
                in_seen++;
                last_in_cyc = cyc;
                if (stall_on && (in_seen % 2) == 0) stall_left = 5;
            end
            if (dst_wr) begin
                if (n_wr < 32) begin
                    dst_a[n_wr] = dst_addr;
                    dst_d[n_wr] = dst_data;
                end
                n_wr++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (host_busy && cte_op_mode != mode_tb) op_bad++;
        end
    end

    task automatic start_job(input logic m, input logic [ADDR_W-1:0] np);
        @(negedge clk);
        mode = m; num_pairs = np; mode_tb = m; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, n_done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_t1();
        src_mem[0] = 24'h000080; src_mem[1] = 24'h000064;
        src_mem[2] = 24'h000080; src_mem[3] = 24'h0000C8;
        res_tab[0] = 24'h111111; res_tab[1] = 24'h222222; n_res = 2;
    endtask

    task automatic check_t1(input string p);
        logic [23:0] exp_in [4];
        exp_in = '{24'h80, 24'h64, 24'h80, 24'hC8};
        check({p, "_in_cnt"}, in_seen, 4);
        for (int i = 0; i < 4; i++) check($sformatf("%s_yuv%0d", p, i), in_log[i], exp_in[i]);
        check({p, "_wr_cnt"}, n_wr, 2);
        check({p, "_a0"}, dst_a[0], 0);
        check({p, "_d0"}, dst_d[0], 24'h111111);
        check({p, "_a1"}, dst_a[1], 1);
        check({p, "_d1"}, dst_d[1], 24'h222222);
        check({p, "_err"}, err_timeout, 0);
        check({p, "_one_done"}, n_done, 1);
    endtask

    initial begin : main
        logic [23:0] exp_rgb [4];
        logic [23:0] exp_t3  [4];
        int k;
        mode_tb = 1'b0;
        n_res = 0;
        clear_stub();
        repeat (3) @(negedge clk);
        check("rst_ctrl", {host_busy, done, err_timeout, src_rd, dst_wr, cte_op_mode, cte_in_en}, 0);
        check("rst_bus", |{src_addr, dst_addr, dst_data, cte_yuv_in, cte_rgb_in}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", host_busy, 0);

        // 1: mode 0, one pair
        clear_stub(); load_t1();
        start_job(1'b0, 16'd1);
        check("t1_busy", host_busy, 1);
        wait_done("t1_done", 200);
        check_t1("t1");
        check("t1_idle", host_busy, 0);

        // 2: mode 1, two pairs
        clear_stub();
        exp_rgb = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};
        for (int i = 0; i < 4; i++) src_mem[i] = exp_rgb[i];
        for (int i = 0; i < 8; i++) res_tab[i] = 24'(i + 1);
        n_res = 8;
        start_job(1'b1, 16'd2);
        wait_done("t2_done", 200);
        check("t2_in_cnt", in_seen, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_rgb%0d", i), in_log[i], exp_rgb[i]);
        check("t2_wr_cnt", n_wr, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_a%0d", i), dst_a[i], i);
            check($sformatf("t2_d%0d", i), dst_d[i], i + 1);
        end
        check("t2_opmode", op_bad, 0);

        // 3: busy stalls after every 2nd input
        clear_stub(); stall_on = 1'b1;
        for (int i = 0; i < 8; i++) src_mem[i] = 24'(8'h10 * (i + 1));
        exp_t3 = '{24'hA1A1A1, 24'hB2B2B2, 24'hC3C3C3, 24'hD4D4D4};
        for (int i = 0; i < 4; i++) res_tab[i] = exp_t3[i];
        n_res = 4;
        start_job(1'b0, 16'd2);
        wait_done("t3_done", 300);
        check("t3_in_cnt", in_seen, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t3_yuv%0d", i), in_log[i], (i + 1) * 16);
        check("t3_busy_viol", busy_viol, 0);
        check("t3_wr_cnt", n_wr, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_a%0d", i), dst_a[i], i);
            check($sformatf("t3_d%0d", i), dst_d[i], exp_t3[i]);
        end
        check("t3_err", err_timeout, 0);

        // 4: empty job
        clear_stub();
        start_job(1'b0, 16'd0);
        wait_done("t4_done", 20);
        check("t4_latency", done_cyc - start_cyc, 2);
        check("t4_rd", n_rd, 0);
        check("t4_in", in_seen, 0);
        check("t4_wr", n_wr, 0);
        check("t4_err", err_timeout, 0);

        // 5: results never come back -> watchdog abort
        clear_stub(); load_t1(); out_en = 1'b0;
        start_job(1'b0, 16'd1);
        wait_done("t5_done", 200);
        check("t5_in_cnt", in_seen, 4);
        check("t5_gap", done_cyc - last_in_cyc, 18);
        check("t5_err", err_timeout, 1);
        check("t5_wr", n_wr, 0);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", err_timeout, 1);

        // 6: reset mid-run, then a fresh job
        clear_stub();
        for (int i = 0; i < 8; i++) src_mem[i] = 24'(8'h10 * (i + 1));
        n_res = 4;
        start_job(1'b0, 16'd2);
        check("t6_err_clr", err_timeout, 0);
        k = 0;
        while (in_seen < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_mid_run", in_seen >= 2, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_ctrl", {host_busy, done, err_timeout, src_rd, dst_wr, cte_op_mode, cte_in_en}, 0);
        check("t6_rst_bus", |{src_addr, dst_addr, dst_data, cte_yuv_in, cte_rgb_in}, 0);
        repeat (2) @(negedge clk);
        check("t6_rst_hold", {host_busy, done, src_rd, dst_wr, cte_in_en}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_no_done", n_done, 0);
        clear_stub(); load_t1();
        start_job(1'b0, 16'd1);
        wait_done("t6_done", 200);
        check("t6_first_addr", first_rd_addr, 0);
        check_t1("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
